// File: rtl/uart_fifo_mmio.sv
// MMIO UART with TX/RX circular FIFOs, optional even/odd parity, sticky error flags
// and a registered level interrupt.
module uart_fifo_mmio #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_RESET = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_address,
  input  logic [31:0] data_store,
  output logic [31:0] data_fetch,
  input  logic        data_read,
  input  logic        data_enable,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [15:0]   r_baud;
  logic [4:0]    r_ctrl;
  logic          r_ovr, r_perr, r_ferr, r_drop, r_irq;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  state_e        r_tx_st, r_rx_st;
  logic [15:0]   r_tx_clk, r_tx_div, r_rx_clk, r_rx_div;
  logic [2:0]    r_tx_bit, r_rx_bit;
  logic [7:0]    r_tx_sh, r_rx_sh;
  logic          r_tx_par, r_ser_tx, r_rx_pbit;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;

  logic [4:0] w_off;
  logic       w_rd, w_wr, w_w1c;
  logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_busy;
  logic       w_tx_push, w_tx_pop, w_tx_end, w_drop_set;
  logic       w_rx_push, w_rx_pop, w_rx_done, w_rx_pbad, w_rx_good;
  logic       w_ovr_set, w_perr_set, w_ferr_set;
  logic [7:0] w_tx_head, w_rx_head;
  logic       w_unused;

  assign w_off      = data_address[4:0];
  assign w_rd       = data_enable & data_read;
  assign w_wr       = data_enable & ~data_read;
  assign w_w1c      = w_wr & (w_off == 5'h0C);
  assign w_unused   = ^{data_address[31:5], data_store[31:16]};

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL);
  assign w_tx_head  = r_tx_mem[r_tx_rp];
  assign w_rx_head  = r_rx_mem[r_rx_rp];
  assign w_tx_busy  = (r_tx_st != StIdle);

  // The transmitter pops the head byte whenever it starts a frame.
  assign w_tx_end   = (r_tx_clk == r_tx_div - 16'd1);
  assign w_tx_pop   = ~w_tx_empty & ((r_tx_st == StIdle) | ((r_tx_st == StStop) & w_tx_end));
  assign w_tx_push  = w_wr & (w_off == 5'h08) & (~w_tx_full | w_tx_pop);
  assign w_drop_set = w_wr & (w_off == 5'h08) & ~w_tx_push;

  assign w_rx_pop   = w_rd & (w_off == 5'h04) & ~w_rx_empty;
  assign w_rx_done  = (r_rx_st == StStop) & (r_rx_clk == r_rx_div);
  assign w_rx_pbad  = r_ctrl[0] & ((^{r_rx_sh, r_rx_pbit}) != r_ctrl[1]);
  assign w_ferr_set = w_rx_done & ~r_rx_s2;
  assign w_perr_set = w_rx_done & r_rx_s2 & w_rx_pbad;
  assign w_rx_good  = w_rx_done & r_rx_s2 & ~w_rx_pbad;
  assign w_rx_push  = w_rx_good & (~w_rx_full | w_rx_pop);
  assign w_ovr_set  = w_rx_good & w_rx_full & ~w_rx_pop;

  assign ser_tx = r_ser_tx;
  assign irq    = r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud <= 16'(BAUD_RESET);
      r_ctrl <= '0;
      r_ovr  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_drop <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && w_off == 5'h00) begin
        r_baud <= (data_store[15:0] < 16'd4) ? 16'd4 : data_store[15:0];
      end
      if (w_wr && w_off == 5'h10) r_ctrl <= data_store[4:0];
      // A set event in the same cycle as its W1C keeps the flag set.
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_w1c & data_store[4]));
      r_perr <= w_perr_set | (r_perr & ~(w_w1c & data_store[5]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_w1c & data_store[6]));
      r_drop <= w_drop_set | (r_drop & ~(w_w1c & data_store[10]));
      r_irq  <= (r_ctrl[2] & ~w_rx_empty) | (r_ctrl[3] & w_tx_empty) |
                (r_ctrl[4] & (r_ovr | r_perr | r_ferr | r_drop));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= data_store[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st  <= StIdle;
      r_tx_clk <= '0;
      r_tx_div <= 16'(BAUD_RESET);
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
      r_ser_tx <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_st  <= StStart;
      r_tx_clk <= '0;
      r_tx_div <= r_baud;
      r_tx_sh  <= w_tx_head;
      r_tx_par <= (^w_tx_head) ^ r_ctrl[1];
      r_ser_tx <= 1'b0;
    end else if (r_tx_st != StIdle) begin
      if (!w_tx_end) begin
        r_tx_clk <= r_tx_clk + 16'd1;
      end else begin
        r_tx_clk <= '0;
        case (r_tx_st)
          StStart: begin
            r_tx_st  <= StData;
            r_tx_bit <= '0;
            r_ser_tx <= r_tx_sh[0];
          end
          StData: begin
            if (r_tx_bit == 3'd7) begin
              r_tx_st  <= r_ctrl[0] ? StParity : StStop;
              r_ser_tx <= r_ctrl[0] ? r_tx_par : 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
              r_ser_tx <= r_tx_sh[1];
            end
          end
          StParity: begin
            r_tx_st  <= StStop;
            r_ser_tx <= 1'b1;
          end
          default: begin
            r_tx_st  <= StIdle;
            r_ser_tx <= 1'b1;
          end
        endcase
      end
    end
  end

  // Bit timing counts from 1 on the cycle after the synchronised falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= StIdle;
      r_rx_clk  <= '0;
      r_rx_div  <= 16'(BAUD_RESET);
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_pbit <= 1'b0;
    end else begin
      r_rx_s1   <= ser_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_st)
        StIdle: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_st  <= StStart;
            r_rx_clk <= 16'd1;
            r_rx_div <= r_baud;
          end
        end
        StStart: begin
          if (r_rx_clk == (r_rx_div >> 1)) begin
            r_rx_st  <= r_rx_s2 ? StIdle : StData;
            r_rx_clk <= 16'd1;
            r_rx_bit <= '0;
          end else begin
            r_rx_clk <= r_rx_clk + 16'd1;
          end
        end
        StData: begin
          if (r_rx_clk == r_rx_div) begin
            r_rx_clk <= 16'd1;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_st <= r_ctrl[0] ? StParity : StStop;
          end else begin
            r_rx_clk <= r_rx_clk + 16'd1;
          end
        end
        StParity: begin
          if (r_rx_clk == r_rx_div) begin
            r_rx_clk  <= 16'd1;
            r_rx_pbit <= r_rx_s2;
            r_rx_st   <= StStop;
          end else begin
            r_rx_clk <= r_rx_clk + 16'd1;
          end
        end
        default: begin
          if (r_rx_clk == r_rx_div) r_rx_st <= StIdle;
          else r_rx_clk <= r_rx_clk + 16'd1;
        end
      endcase
    end
  end

  always_comb begin
    data_fetch = 32'h0;
    if (w_rd) begin
      case (w_off)
        5'h00:   data_fetch = {16'h0, r_baud};
        5'h04:   data_fetch = {24'h0, w_rx_empty ? 8'h00 : w_rx_head};
        5'h0C:   data_fetch = {21'h0, r_drop, r_ser_tx, r_rx_s2, w_tx_busy, r_ferr, r_perr,
                               r_ovr, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
        5'h10:   data_fetch = {27'h0, r_ctrl};
        5'h14:   data_fetch = {16'h0, 8'(r_rx_cnt), 8'(r_tx_cnt)};
        default: data_fetch = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Scoreboard bench for uart_fifo_mmio: stimulus queues expected read data / line levels,
// a negedge monitor pops and compares whenever a read or probe is presented.
module tb_uart_fifo_mmio;
  localparam logic [4:0] BAUD = 5'h00, RXD = 5'h04, TXD = 5'h08, STAT = 5'h0C;
  localparam logic [4:0] CTRL = 5'h10, LVL = 5'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, store = '0;
  logic        rd = 1'b0, en = 1'b0;
  logic        ext_rx = 1'b1, loop = 1'b0, probe = 1'b0;
  logic        ser_rx_w, ser_tx_w, irq_w;
  logic [31:0] fetch;

  int          checks = 0;
  int          errors = 0;
  int          q_kind[$];
  string       q_name[$];
  logic [31:0] q_val[$];

  assign ser_rx_w = loop ? ser_tx_w : ext_rx;

  uart_fifo_mmio #(.FIFO_DEPTH(4), .BAUD_RESET(434)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_address (addr),
    .data_store   (store),
    .data_fetch   (fetch),
    .data_read    (rd),
    .data_enable  (en),
    .ser_rx       (ser_rx_w),
    .ser_tx       (ser_tx_w),
    .irq          (irq_w)
  );

  always #5 clk = ~clk;

  // Monitor: kind 0 = bus read data, 1 = ser_tx level, 2 = irq level.
  always @(negedge clk) begin
    if ((en && rd) || probe) begin
      if (q_val.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: fetch=%h ser_tx=%b irq=%b with no expectation queued",
                 fetch, ser_tx_w, irq_w);
      end else begin
        automatic int          k  = q_kind.pop_front();
        automatic string       nm = q_name.pop_front();
        automatic logic [31:0] ev = q_val.pop_front();
        automatic logic [31:0] act;
        case (k)
          0:       act = fetch;
          1:       act = {31'h0, ser_tx_w};
          default: act = {31'h0, irq_w};
        endcase
        checks++;
        if (act !== ev) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, act, ev);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    en = 1'b0; rd = 1'b0; probe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    en = 1'b1; rd = 1'b0; probe = 1'b0; addr = {27'h0, a}; store = d;
  endtask

  task automatic rdx(input logic [4:0] a, input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    en = 1'b1; rd = 1'b1; probe = 1'b0; addr = {27'h0, a};
    q_kind.push_back(0); q_name.push_back(nm); q_val.push_back(e);
  endtask

  task automatic prb(input int k, input logic e, input string nm);
    @(posedge clk); #1;
    en = 1'b0; rd = 1'b0; probe = 1'b1;
    q_kind.push_back(k); q_name.push_back(nm); q_val.push_back({31'h0, e});
  endtask

  task automatic drive_bit(input logic v);
    tick();
    ext_rx = v;
    idle(15);
  endtask

  // External frame at 16 clocks/bit. Mode 1 pops RXDATA on the stop-sample cycle,
  // mode 2 probes irq on the two cycles after the byte lands.
  task automatic send(input logic [7:0] b, input logic pen, input logic pb, input logic stp,
                      input int mode, input logic [7:0] e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (pen) drive_bit(pb);
    tick();
    ext_rx = stp;
    case (mode)
      1: begin
        idle(9);
        rdx(RXD, {24'h0, e}, "rx_pop_on_full_push");
        idle(5);
      end
      2: begin
        idle(10);
        prb(2, 1'b0, "irq_same_cycle_as_land");
        prb(2, 1'b1, "irq_one_after_land");
        idle(3);
      end
      default: idle(15);
    endcase
    tick();
    ext_rx = 1'b1;
    idle(4);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    idle(3);
    prb(1, 1'b1, "reset_ser_tx");
    prb(2, 1'b0, "reset_irq");
    rst = 1'b0;
    rdx(BAUD, 32'h1B2, "reset_baud");
    rdx(STAT, 32'h305, "reset_status");
    rdx(CTRL, 32'h0, "reset_ctrl");
    rdx(LVL, 32'h0, "reset_level");
    wr(5'h18, 32'hFFFF_FFFF);
    rdx(5'h18, 32'h0, "unmapped_read");
    wr(BAUD, 32'h2);
    rdx(BAUD, 32'h4, "baud_clamp");

    // Loopback, two back-to-back frames
    wr(BAUD, 32'd16);
    loop = 1'b1;
    wr(TXD, 32'hA5);
    prb(1, 1'b1, "tx_idle_cycle_n1");
    prb(1, 1'b0, "tx_start_cycle_n2");
    wr(TXD, 32'h3C);
    idle(13);
    prb(1, 1'b0, "tx_start_last");
    prb(1, 1'b1, "tx_bit0_a5");
    idle(15);
    prb(1, 1'b0, "tx_bit1_a5");
    idle(126);
    prb(1, 1'b1, "tx_stop_last");
    prb(1, 1'b0, "tx_b2b_start");
    idle(200);
    rdx(LVL, 32'h0200, "loop_level");
    rdx(RXD, 32'hA5, "loop_rx0");
    rdx(RXD, 32'h3C, "loop_rx1");
    rdx(RXD, 32'h0, "loop_empty_read");
    loop = 1'b0;

    // Odd parity
    wr(CTRL, 32'h3);
    send(8'h03, 1'b1, 1'b0, 1'b1, 0, 8'h0);
    rdx(STAT, 32'h325, "parity_bad_status");
    send(8'h03, 1'b1, 1'b1, 1'b1, 0, 8'h0);
    rdx(LVL, 32'h0100, "parity_ok_level");
    rdx(RXD, 32'h03, "parity_ok_byte");
    rdx(STAT, 32'h325, "parity_err_sticky");
    wr(STAT, 32'h20);
    rdx(STAT, 32'h305, "parity_err_cleared");
    wr(CTRL, 32'h0);

    // Framing error and start glitch
    send(8'h5A, 1'b0, 1'b0, 1'b0, 0, 8'h0);
    rdx(STAT, 32'h345, "frame_err_status");
    rdx(LVL, 32'h0, "frame_err_discard");
    wr(STAT, 32'h40);
    tick();
    ext_rx = 1'b0;
    idle(2);
    tick();
    ext_rx = 1'b1;
    idle(30);
    rdx(STAT, 32'h305, "glitch_status");
    rdx(LVL, 32'h0, "glitch_level");

    // RX overrun with depth 4
    send(8'h11, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h22, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h33, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h44, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h55, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    rdx(LVL, 32'h0400, "ovr_level");
    rdx(STAT, 32'h319, "ovr_status");
    rdx(RXD, 32'h11, "ovr_rx0");
    rdx(RXD, 32'h22, "ovr_rx1");
    rdx(RXD, 32'h33, "ovr_rx2");
    rdx(RXD, 32'h44, "ovr_rx3");
    wr(STAT, 32'h10);
    rdx(STAT, 32'h305, "ovr_cleared");

    // Pop coinciding with the push into a full FIFO
    send(8'h61, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h62, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h63, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h64, 1'b0, 1'b0, 1'b1, 0, 8'h0);
    send(8'h65, 1'b0, 1'b0, 1'b1, 1, 8'h61);
    rdx(LVL, 32'h0400, "popfull_level");
    rdx(STAT, 32'h309, "popfull_no_overrun");
    rdx(RXD, 32'h62, "popfull_rx1");
    rdx(RXD, 32'h63, "popfull_rx2");
    rdx(RXD, 32'h64, "popfull_rx3");
    rdx(RXD, 32'h65, "popfull_rx4");

    // RX interrupt
    wr(CTRL, 32'h4);
    prb(2, 1'b0, "irq_rx_idle");
    send(8'h5A, 1'b0, 1'b0, 1'b1, 2, 8'h0);
    rdx(RXD, 32'h5A, "irq_rx_byte");
    idle(1);
    prb(2, 1'b0, "irq_rx_drained");

    // TX drop, then reset mid-frame
    wr(CTRL, 32'h10);
    wr(BAUD, 32'd100);
    wr(TXD, 32'h00);
    wr(TXD, 32'h01);
    wr(TXD, 32'h02);
    wr(TXD, 32'h03);
    wr(TXD, 32'h04);
    wr(TXD, 32'h05);
    rdx(STAT, 32'h586, "tx_drop_status");
    rdx(LVL, 32'h0004, "tx_drop_level");
    prb(2, 1'b1, "tx_drop_irq");
    prb(1, 1'b0, "tx_slow_start");
    idle(300);
    prb(1, 1'b0, "tx_mid_frame");
    @(posedge clk); #1;
    en = 1'b0; rd = 1'b0; rst = 1'b1; probe = 1'b1;
    q_kind.push_back(1); q_name.push_back("rst_ser_tx"); q_val.push_back(32'h1);
    prb(2, 1'b0, "rst_irq");
    @(posedge clk); #1;
    probe = 1'b0; rst = 1'b0;
    rdx(LVL, 32'h0, "rst_level");
    rdx(BAUD, 32'h1B2, "rst_baud");
    rdx(STAT, 32'h305, "rst_status");
    rdx(CTRL, 32'h0, "rst_ctrl");
    idle(5);

    if (q_val.size() != 0) begin
      errors += q_val.size();
      $display("FAIL pending_expectations: got %0d left expected 0", q_val.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_mmio.md
# uart_fifo_mmio

Parametrised, interrupt-capable UART peripheral for the SoC MMIO bus. It is the next-generation UART and adds TX and RX FIFOs of configurable depth, optional even/odd parity, and sticky error flags with a level interrupt. It uses the same single-cycle MMIO access protocol as the existing IO blocks and sits on the IO bus beside them.

## Interface
- FIFO_DEPTH, 8, entries per TX/RX FIFO; power of 2, 2..128
- BAUD_RESET, 434, reset divisor in clocks per bit (115200 baud at 50 MHz)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- data_address  in  32  byte address; bits [4:0] decoded, word aligned
- data_store  in  32  write data
- data_fetch  out  32  read data; combinational; 0 when no read is active
- data_read  in  1  1 = read, 0 = write; qualified by data_enable
- data_enable  in  1  one access per cycle while high
- ser_rx  in  1  serial input; asynchronous to clk
- ser_tx  out  1  serial output; registered; idles high
- irq  out  1  level interrupt; registered

## Operation
- Register map (offset from data_address[4:0]):
  - 0x00 BAUD, R/W. Bits [15:0] hold the divisor. Written values below 4 are stored as 4. A new value takes effect at the next frame start on each side.
  - 0x04 RXDATA, R. Returns {24'h0, head byte} and pops that byte. When the RX FIFO is empty the read returns 0 and nothing pops.
  - 0x08 TXDATA, W. Pushes data_store[7:0]. When the TX FIFO is full the byte is dropped and tx_drop is set.
  - 0x0C STATUS, R/W1C:
    - [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full
    - [4] rx_overrun, [5] parity_err, [6] frame_err, [7] tx_busy
    - [8] ser_rx (synchronised), [9] ser_tx, [10] tx_drop
    - Bits 4, 5, 6 and 10 are sticky. Writing 1 to one of them clears it.
  - 0x10 CTRL, R/W, reset 0: [0] parity_en, [1] parity_odd, [2] rx_irq_en, [3] tx_irq_en, [4] err_irq_en.
  - 0x14 LEVEL, R: [7:0] TX count, [15:8] RX count.
  - Any other offset reads 0 and ignores writes. Reads have no side effect except the RXDATA pop.
- Frame format: start bit (0), 8 data bits LSB first, parity bit when parity_en, one stop bit (1). Even parity makes the total count of 1s even; odd parity makes it odd.
- TX FSM states: IDLE, START, DATA, PARITY, STOP. Each bit is held for exactly divisor cycles.
  - IDLE → START when the TX FIFO is non-empty; the head byte pops on that transition.
  - DATA → PARITY when parity_en, otherwise DATA → STOP, after 8 bits.
  - After STOP, go to START if the FIFO is non-empty (back-to-back frames, no idle gap), otherwise IDLE.
- RX FSM states: IDLE, START, DATA, PARITY, STOP. ser_rx passes through a 2-flop synchroniser first.
  - IDLE → START on a synchronised falling edge.
  - START samples at divisor/2 (integer division). If the line reads 1, it is a glitch and the FSM returns to IDLE.
  - DATA and PARITY sample every divisor cycles after that point.
  - The STOP sample decides the outcome:
    - Stop bit = 0: set frame_err and discard the byte.
    - Parity mismatch: set parity_err and discard the byte.
    - Otherwise push the byte. If the RX FIFO is full, the new byte is dropped and rx_overrun is set.
  - After STOP the FSM returns to IDLE.
- FIFOs: circular buffers with pointers of clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH; counts run 0..FIFO_DEPTH.
  - A push and a pop in the same cycle both take effect and the count is unchanged. This also applies when the FIFO is full or when it holds 1 entry.
  - An RX push while full succeeds only if an RXDATA pop happens in the same cycle.
- irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty) | (err_irq_en & (rx_overrun | parity_err | frame_err | tx_drop)).

## Timing
- Reset values:
  - ser_tx = 1, irq = 0
  - BAUD = BAUD_RESET, CTRL = 0
  - FIFOs empty, sticky flags 0, both FSMs in IDLE
  - data_fetch is 0 during reset because no access is active.
- Reset asserted mid-frame forces ser_tx to 1 immediately (asynchronously) and discards any frame in progress.
- data_fetch is valid in the same cycle as a read. Register updates caused by a read or write are visible from the next cycle.
- TX latency: a TXDATA write in cycle N to an idle transmitter makes ser_tx go low at the edge ending cycle N+1. A frame lasts 10 × divisor cycles, or 11 × divisor with parity. tx_busy is high from the start bit through the end of the stop bit.
- RX latency: the byte appears in the RX FIFO, with rx_empty low, 1 cycle after the mid-stop sample. The synchroniser adds 2 cycles from a ser_rx edge.
- irq updates 1 cycle after its inputs change.
- Writing 1 to a sticky bit in the same cycle that its set event occurs leaves the bit set (set wins).

## Test plan
- Loopback (ser_tx tied to ser_rx), BAUD=16, parity off. Write 0xA5 then 0x3C to TXDATA → ser_tx low at cycle N+1, frames back-to-back 160 cycles each, RXDATA reads return 0xA5 then 0x3C, then an empty read returns 0.
- Parity_en=1, parity_odd=1. Drive an external frame for 0x03 with parity bit 0 → parity_err=1, rx_empty=1. Drive the same frame with parity bit 1 → byte 0x03 received and parity_err stays set until STATUS is written with 0x20.
- FIFO_DEPTH=4. Receive 5 bytes with no reads → LEVEL[15:8]=4, rx_overrun=1, reads return the first 4 bytes in order. Also a pop coinciding with the 5th push accepts that byte.
- FIFO_DEPTH=4, BAUD=100. Write 6 TX bytes in 6 cycles → byte 1 pops into the FSM, bytes 2-5 fill the FIFO, byte 6 is dropped, tx_drop=1, tx_full=1.
- Stop bit held 0 → frame_err=1 and the byte is discarded. A 3-cycle low glitch at BAUD=16 → no START acceptance and no flags set.
- rx_irq_en=1: irq rises 1 cycle after the first RX byte lands. Assert rst mid-TX-frame → ser_tx=1, irq=0, LEVEL=0, BAUD=434.
